// File: rtl/weight_addr_gen_pkg.sv
// Shared sizing, FSM encoding and segment-length helper for the weight
// address generator.
package weight_addr_gen_pkg;

   localparam int S2P_SIZE         = 8;
   localparam int KERNEL_SIZE      = 4;
   localparam int CHANNELS_SIZE    = 8;
   localparam int KERNEL_NUMS_SIZE = 8;
   localparam int ADDR_SIZE        = 16;

   localparam int IWW_W   = 2*KERNEL_SIZE + CHANNELS_SIZE;
   localparam int LANE_W  = $clog2(S2P_SIZE);
   localparam int WORDS_W = LANE_W + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Length of a tile edge: full S2P_SIZE except on the last row/column of
   // the walk when the remainder field encodes a partial tile.
   function automatic logic [WORDS_W-1:0] seg_count(input logic             at_edge,
                                                    input logic [S2P_SIZE-1:0] rem_m1);
      if (at_edge && (rem_m1 < S2P_SIZE'(S2P_SIZE - 1)))
         return WORDS_W'(rem_m1[LANE_W-1:0]) + WORDS_W'(1);
      return WORDS_W'(S2P_SIZE);
   endfunction

endpackage

// File: rtl/weight_addr_gen_walk_cnt.sv
// Nested group / tile-column / lane counter with wrap flags. Lane is the
// innermost loop; the lane count shrinks on the final group when the kernel
// count is not a multiple of S2P_SIZE.
module tile_walk_cnt
   import weight_addr_gen_pkg::*;
(
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        clear,
   input  logic                        advance,
   input  logic [IWW_W-1:0]            bcn,
   input  logic [KERNEL_NUMS_SIZE-1:0] brn,
   input  logic [S2P_SIZE-1:0]         knr,
   output logic [LANE_W-1:0]           r,
   output logic                        r_wrap,
   output logic                        bc_wrap,
   output logic                        last
);

   logic [KERNEL_NUMS_SIZE-1:0] br;
   logic [IWW_W-1:0]            bc;
   logic                        br_wrap;
   logic [WORDS_W-1:0]          lanes;

   // Wrap flags for each loop level from the current counter values.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      br_wrap = (br == brn - KERNEL_NUMS_SIZE'(1));
      bc_wrap = (bc == bcn);
      lanes   = seg_count(br_wrap, knr);
      r_wrap  = ({1'b0, r} == lanes - WORDS_W'(1));
      last    = br_wrap && bc_wrap && r_wrap;
   end

   // Step lane, carry into column, carry into group; the final beat wraps all to 0.
   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         br <= '0;
         bc <= '0;
         r  <= '0;
      end else if (clear) begin
         br <= '0;
         bc <= '0;
         r  <= '0;
      end else if (advance) begin
         if (!r_wrap) begin
            r <= r + LANE_W'(1);
         end else begin
            r <= '0;
            if (!bc_wrap) begin
               bc <= bc + IWW_W'(1);
            end else begin
               bc <= '0;
               br <= br_wrap ? '0 : br + KERNEL_NUMS_SIZE'(1);
            end
         end
      end
   end

endmodule

// File: rtl/weight_addr_gen.sv
// Weight read-address generator: walks the row-major weight memory in
// S2P_SIZE x S2P_SIZE tiles and streams one segment address per kernel lane.
// Addresses are built from three accumulators so no multiplier is needed.
module weight_addr_gen
   import weight_addr_gen_pkg::*;
(
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        enable,
   input  logic [IWW_W-1:0]            i_bcn,
   input  logic [KERNEL_NUMS_SIZE-1:0] i_brn,
   input  logic [IWW_W-1:0]            i_iww,
   input  logic [S2P_SIZE-1:0]         i_knr,
   input  logic [S2P_SIZE-1:0]         i_iwwr,
   input  logic                        i_ready,
   output logic                        o_valid,
   output logic [ADDR_SIZE-1:0]        o_addr,
   output logic [WORDS_W-1:0]          o_words,
   output logic [LANE_W-1:0]           o_lane,
   output logic                        o_last,
   output logic                        o_done
);

   logic [1:0]                  state;
   logic [IWW_W-1:0]            bcn_q;
   logic [KERNEL_NUMS_SIZE-1:0] brn_q;
   logic [IWW_W-1:0]            iww_q;
   logic [S2P_SIZE-1:0]         knr_q;
   logic [S2P_SIZE-1:0]         iwwr_q;
   logic [ADDR_SIZE-1:0]        grp_step_q;
   logic [ADDR_SIZE-1:0]        grp_base;
   logic [ADDR_SIZE-1:0]        col_off;
   logic [ADDR_SIZE-1:0]        lane_off;

   logic                        running;
   logic                        fire;
   logic                        cnt_clear;
   logic [LANE_W-1:0]           lane;
   logic                        r_wrap;
   logic                        bc_wrap;
   logic                        walk_last;

   assign running   = (state == ST_RUN);
   assign fire      = running && i_ready && enable;
   assign cnt_clear = !running || !enable;

   tile_walk_cnt u_walk (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (cnt_clear),
      .advance (fire),
      .bcn     (bcn_q),
      .brn     (brn_q),
      .knr     (knr_q),
      .r       (lane),
      .r_wrap  (r_wrap),
      .bc_wrap (bc_wrap),
      .last    (walk_last)
   );

   // Sequencer: latch config, track walk state and step the address accumulators.
   // NOTE: config registers are reset too; they are plain flops, not a memory array.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         bcn_q      <= '0;
         brn_q      <= '0;
         iww_q      <= '0;
         knr_q      <= '0;
         iwwr_q     <= '0;
         grp_step_q <= '0;
         grp_base   <= '0;
         col_off    <= '0;
         lane_off   <= '0;
      end else if (!enable) begin
         state    <= ST_IDLE;
         grp_base <= '0;
         col_off  <= '0;
         lane_off <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               bcn_q      <= i_bcn;
               brn_q      <= i_brn;
               iww_q      <= i_iww;
               knr_q      <= i_knr;
               iwwr_q     <= i_iwwr;
               grp_step_q <= ADDR_SIZE'(i_iww) << LANE_W;
               grp_base   <= '0;
               col_off    <= '0;
               lane_off   <= '0;
               state      <= (i_brn == '0) ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
               if (fire) begin
                  if (walk_last) begin
                     state    <= ST_FIN;
                     grp_base <= '0;
                     col_off  <= '0;
                     lane_off <= '0;
                  end else if (r_wrap) begin
                     lane_off <= '0;
                     if (bc_wrap) begin
                        col_off  <= '0;
                        grp_base <= grp_base + grp_step_q;
                     end else begin
                        col_off <= col_off + ADDR_SIZE'(S2P_SIZE);
                     end
                  end else begin
                     lane_off <= lane_off + ADDR_SIZE'(iww_q);
                  end
               end
            end
            ST_FIN:  state <= ST_HOLD;
            default: state <= ST_HOLD;
         endcase
      end
   end

   // Beat outputs are held at zero whenever no beat is being presented.
   always_comb begin
      o_valid = running;
      o_addr  = '0;
      o_words = '0;
      o_lane  = '0;
      o_last  = 1'b0;
      o_done  = (state == ST_FIN);
      if (running) begin
         o_addr  = grp_base + col_off + lane_off;
         o_words = seg_count(bc_wrap, iwwr_q);
         o_lane  = lane;
         o_last  = walk_last;
      end
   end

endmodule
